piso_unloader: RTL and testbench

- Parallel-in, serial-out unloader: the unload direction of the delay-line shift register used in the max16 datapath.
- Accepts one full frame of LENGTH words in a single handshake, then emits the words one per accepted beat on a valid/ready stream, with a last flag.
- Sits between frame-wide producers (window snapshot, max16 result bank) and word-serial consumers.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_unloader_running_max.sv | 50 +++++
 rtl/piso_unloader.sv | 89 ++++++++
 tb/tb_piso_unloader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO unloader and the max16 datapath.
package piso_pkg;

  localparam int unsigned PISO_DATA_WIDTH = 8;
  localparam int unsigned PISO_LENGTH     = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  function automatic int unsigned cnt_width(input int unsigned len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/piso_unloader_running_max.sv
// Running unsigned maximum over accepted words, published with a one-cycle pulse
// on the cycle after a frame's last beat.
module piso_running_max #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  beat_i,
  input  logic                  first_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] run_q, run_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0] cand;

  always_comb begin
    cand    = (first_i || word_i > run_q) ? word_i : run_q;
    run_d   = run_q;
    max_d   = max_q;
    pulse_d = 1'b0;
    if (beat_i) begin
      run_d = cand;
      if (last_i) begin
        max_d   = cand;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q   <= '0;
      max_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      max_q   <= max_d;
      pulse_q <= pulse_d;
    end
  end

  assign max_o   = max_q;
  assign valid_o = pulse_q;

endmodule

// File: rtl/piso_unloader.sv
// Parallel-in serial-out frame unloader on a valid/ready stream.
// Optional running-max tracking under `define PISO_TRACK_MAX_EN.
module piso_unloader
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PISO_DATA_WIDTH,
  parameter int unsigned LENGTH     = PISO_LENGTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [DATA_WIDTH*LENGTH-1:0] din,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef PISO_TRACK_MAX_EN
  output logic                         out_last,
  output logic [DATA_WIDTH-1:0]        max_out,
  output logic                         max_valid
`else
  output logic                         out_last
`endif
);

  localparam int unsigned CW = cnt_width(LENGTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

  piso_state_e                  state_q, state_d;
  logic [DATA_WIDTH*LENGTH-1:0] buf_q, buf_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         load, beat;

  assign out_valid = (state_q == SHIFT);
  assign out_last  = out_valid && (cnt_q == CNT_LAST);
  assign dout      = buf_q[DATA_WIDTH-1:0];
  // Ready during the last beat lets the next frame follow without a bubble.
  assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
  assign load      = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    if (load) begin
      buf_d   = din;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (beat) begin
      if (out_last) begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        buf_d = buf_q >> DATA_WIDTH;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PISO_TRACK_MAX_EN
  piso_running_max #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_running_max (
    .clk     (clk),
    .rstn    (rstn),
    .beat_i  (beat),
    .first_i (cnt_q == '0),
    .last_i  (out_last),
    .word_i  (dout),
    .max_o   (max_out),
    .valid_o (max_valid)
  );
`endif

endmodule

// File: tb/tb_piso_unloader.sv
// Directed self-checking bench for piso_unloader (DATA_WIDTH=8, LENGTH=16).
// Max-tracking checks compile in when PISO_TRACK_MAX_EN is defined.
module tb_piso_unloader;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [DW*LN-1:0] din;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  dout;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
`ifdef PISO_TRACK_MAX_EN
  logic [DW-1:0]  max_out;
  logic           max_valid;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_unloader #(
    .DATA_WIDTH(DW),
    .LENGTH    (LN)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PISO_TRACK_MAX_EN
    .out_last  (out_last),
    .max_out   (max_out),
    .max_valid (max_valid)
`else
    .out_last  (out_last)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*LN-1:0] ramp(input logic [7:0] base);
    logic [DW*LN-1:0] f;
    f = '0;
    for (int i = 0; i < LN; i++) f[DW*i +: DW] = base + 8'(i);
    return f;
  endfunction

  task automatic load_frame(input logic [DW*LN-1:0] f);
    din      = f;
    in_valid = 1'b1;
    #1;
    chk("load_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [DW*LN-1:0] fm;

    // Reset held with a frame offered: nothing may load.
    rstn      = 1'b0;
    in_valid  = 1'b1;
    din       = ramp(8'h40);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout",      32'(dout),      32'h00);
    chk("rst_out_last",  32'(out_last),  32'd0);
`ifdef PISO_TRACK_MAX_EN
    chk("rst_max_out",   32'(max_out),   32'h00);
    chk("rst_max_valid", 32'(max_valid), 32'd0);
`endif
    in_valid = 1'b0;
    rstn     = 1'b1;
    step();
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    // Basic frame
    load_frame(ramp(8'h00));
    for (int i = 0; i < LN; i++) begin
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_dout",  32'(dout),      32'(i));
      chk("basic_last",  32'(out_last),  32'(i == LN - 1));
      step();
    end
    chk("basic_end_valid", 32'(out_valid), 32'd0);
    chk("basic_end_dout",  32'(dout),      32'h00);
    chk("basic_end_ready", 32'(in_ready),  32'd1);

    // Backpressure while word 5 is presented
    load_frame(ramp(8'h00));
    for (int i = 0; i < LN; i++) begin
      chk("bp_dout", 32'(dout), 32'(i));
      if (i == 5) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          step();
          chk("bp_hold_dout",  32'(dout),      32'h05);
          chk("bp_hold_valid", 32'(out_valid), 32'd1);
          chk("bp_hold_ready", 32'(in_ready),  32'd0);
          chk("bp_hold_last",  32'(out_last),  32'd0);
        end
        out_ready = 1'b1;
      end
      step();
    end
    chk("bp_end_valid", 32'(out_valid), 32'd0);

    // Back-to-back frames with the second load on the first's last beat
    load_frame(ramp(8'h00));
    for (int i = 0; i < LN; i++) begin
      chk("b2b_a_dout", 32'(dout), 32'(i));
      if (i == 0) chk("b2b_busy_ready", 32'(in_ready), 32'd0);
      if (i == LN - 1) begin
        din      = ramp(8'h10);
        in_valid = 1'b1;
        #1;
        chk("b2b_last_ready", 32'(in_ready), 32'd1);
      end
      step();
    end
    in_valid = 1'b0;
`ifdef PISO_TRACK_MAX_EN
    chk("b2b_a_max_pulse", 32'(max_valid), 32'd1);
    chk("b2b_a_max_out",   32'(max_out),   32'h0F);
`endif
    for (int i = 0; i < LN; i++) begin
      chk("b2b_b_valid", 32'(out_valid), 32'd1);
      chk("b2b_b_dout",  32'(dout),      32'h10 + 32'(i));
      if (i == 4) begin
        din      = ramp(8'h80);  // offered while busy: must be ignored
        in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
    end
    chk("b2b_end_valid", 32'(out_valid), 32'd0);
`ifdef PISO_TRACK_MAX_EN
    chk("b2b_b_max_out", 32'(max_out), 32'h1F);
`endif

    // Asynchronous reset mid-frame at word 7
    load_frame(ramp(8'h00));
    for (int i = 0; i < 7; i++) step();
    chk("mrst_pre_dout", 32'(dout), 32'h07);
    #2;
    rstn = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_dout",  32'(dout),      32'h00);
    chk("mrst_last",  32'(out_last),  32'd0);
    chk("mrst_ready", 32'(in_ready),  32'd1);
    step();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mrst_no_stale", 32'(out_valid), 32'd0);
    end
    chk("mrst_after_ready", 32'(in_ready), 32'd1);

`ifdef PISO_TRACK_MAX_EN
    // Peak at index 9, then an all-0x01 frame
    fm = ramp(8'h00);
    fm[DW*9 +: DW] = 8'hA7;
    load_frame(fm);
    for (int i = 0; i < LN; i++) begin
      chk("max_no_early_pulse", 32'(max_valid), 32'd0);
      step();
    end
    chk("max_pulse",      32'(max_valid), 32'd1);
    chk("max_a7",         32'(max_out),   32'hA7);
    step();
    chk("max_pulse_once", 32'(max_valid), 32'd0);
    chk("max_a7_hold",    32'(max_out),   32'hA7);
    fm = '0;
    for (int i = 0; i < LN; i++) fm[DW*i +: DW] = 8'h01;
    load_frame(fm);
    for (int i = 0; i < LN; i++) step();
    chk("max_ones_pulse", 32'(max_valid), 32'd1);
    chk("max_ones",       32'(max_out),   32'h01);
`else
    fm = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
